// File: rtl/iec_sd_pkg.sv
// Shared types and constants for the IEC drive SD-channel arbiter.
package iec_sd_pkg;

  localparam int unsigned LBA_W = 32;
  localparam int unsigned BLK_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    RELEASE
  } arb_state_e;

  // The 2-bit owner index limits the arbiter to four drives.
  function automatic int unsigned clamp_drives(input int unsigned d);
    if (d < 1) return 1;
    if (d > 4) return 4;
    return d;
  endfunction

endpackage

// File: rtl/iec_sd_arbiter_if.sv
// SD block-transfer signals: per-drive side and single host side.
interface iec_sd_arbiter_if import iec_sd_pkg::*; #(
  parameter int unsigned DRIVES = 2
);

  localparam int unsigned NDR = clamp_drives(DRIVES);

  logic [NDR-1:0][LBA_W-1:0] drv_lba;
  logic [NDR-1:0][BLK_W-1:0] drv_blk_cnt;
  logic [NDR-1:0]            drv_rd;
  logic [NDR-1:0]            drv_wr;
  logic [NDR-1:0][7:0]       drv_buff_din;
  logic [NDR-1:0]            drv_ack;
  logic [NDR-1:0]            drv_buff_wr;

  logic [LBA_W-1:0]          host_lba;
  logic [BLK_W-1:0]          host_blk_cnt;
  logic                      host_rd;
  logic                      host_wr;
  logic                      host_ack;
  logic                      host_buff_wr;
  logic [7:0]                host_buff_din;

  modport master (
    input  drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din,
    input  host_ack, host_buff_wr,
    output drv_ack, drv_buff_wr,
    output host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din
  );

  modport slave (
    output drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din,
    output host_ack, host_buff_wr,
    input  drv_ack, drv_buff_wr,
    input  host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din
  );

endinterface

// File: rtl/iec_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module iec_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic         valid,
  output logic [1:0]   idx
);

  always_comb begin
    int unsigned cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = ({30'd0, ptr} + off) % N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && (j == cand) && req[j]) begin
          valid = 1'b1;
          idx   = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin sharing of one SD host channel among up to four IEC drives;
// ack and buffer strobes are routed back to the current owner only.
module iec_sd_arbiter import iec_sd_pkg::*; #(
  parameter int unsigned DRIVES  = 2,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                clk_sys,
  input  logic                reset,
  iec_sd_arbiter_if.master    sd,
  output logic                busy,
  output logic [1:0]          owner,
  output logic                timeout
);

  localparam int unsigned NDR   = clamp_drives(DRIVES);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic             host_rd_q, host_rd_d;
  logic             host_wr_q, host_wr_d;
  logic [NDR-1:0]   drv_ack_q, drv_ack_d;
  logic [LBA_W-1:0] host_lba_q, host_lba_d;
  logic [BLK_W-1:0] host_blk_cnt_q, host_blk_cnt_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [LBA_W-1:0] win_lba;
  logic [BLK_W-1:0] win_blk;
  logic             win_rd;
  logic             win_wr;
  logic [NDR-1:0]   owner_oh;
  logic [NDR-1:0]   buff_wr;
  logic [7:0]       buff_din;
  logic [1:0]       owner_next;

  iec_rr_pick #(.N(NDR)) u_pick (
    .req   (sd.drv_rd | sd.drv_wr),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    win_lba = '0;
    win_blk = '0;
    win_rd  = 1'b0;
    win_wr  = 1'b0;
    for (int unsigned j = 0; j < NDR; j++) begin
      if (pick_idx == 2'(j)) begin
        win_lba = sd.drv_lba[j];
        win_blk = sd.drv_blk_cnt[j];
        win_rd  = sd.drv_rd[j];
        win_wr  = sd.drv_wr[j];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    buff_wr  = '0;
    buff_din = '0;
    for (int unsigned j = 0; j < NDR; j++) begin
      if (owner_q == 2'(j)) begin
        owner_oh[j] = 1'b1;
        buff_wr[j]  = (state_q == XFER) && sd.host_buff_wr;
        buff_din    = sd.drv_buff_din[j];
      end
    end
  end

  assign owner_next = (owner_q == 2'(NDR - 1)) ? 2'd0 : owner_q + 2'd1;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    host_rd_d      = host_rd_q;
    host_wr_d      = host_wr_q;
    drv_ack_d      = drv_ack_q;
    host_lba_d     = host_lba_q;
    host_blk_cnt_d = host_blk_cnt_q;
    timeout_d      = 1'b0;
    cnt_d          = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d        = pick_idx;
          host_lba_d     = win_lba;
          host_blk_cnt_d = win_blk;
          host_rd_d      = win_rd;
          host_wr_d      = win_wr & ~win_rd;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (sd.host_ack) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          drv_ack_d = owner_oh;
          state_d   = XFER;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          // Abandon without ack; a drive still requesting simply retries later.
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = owner_next;
          state_d   = IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (!sd.host_ack) state_d = RELEASE;
      end
      RELEASE: begin
        drv_ack_d = '0;
        ptr_d     = owner_next;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      host_rd_q      <= 1'b0;
      host_wr_q      <= 1'b0;
      drv_ack_q      <= '0;
      host_lba_q     <= '0;
      host_blk_cnt_q <= '0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      host_rd_q      <= host_rd_d;
      host_wr_q      <= host_wr_d;
      drv_ack_q      <= drv_ack_d;
      host_lba_q     <= host_lba_d;
      host_blk_cnt_q <= host_blk_cnt_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
    end
  end

  assign sd.drv_ack       = drv_ack_q;
  assign sd.drv_buff_wr   = buff_wr;
  assign sd.host_lba      = host_lba_q;
  assign sd.host_blk_cnt  = host_blk_cnt_q;
  assign sd.host_rd       = host_rd_q;
  assign sd.host_wr       = host_wr_q;
  assign sd.host_buff_din = buff_din;
  assign busy             = busy_q;
  assign owner            = owner_q;
  assign timeout          = timeout_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Bench for iec_sd_arbiter (4 drives, TIMEOUT=8): grant vector table, scoreboard, corner sequences.
module tb_iec_sd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  always #5 clk = ~clk;

  iec_sd_arbiter_if #(.DRIVES(4)) sd_if ();

  iec_sd_arbiter #(.DRIVES(4), .TIMEOUT(8)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .sd      (sd_if.master),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic        rd;
    logic        wr;
  } grant_t;

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    logic [1:0] owner;
    logic       hrd;
    logic       hwr;
    int         ack_len;
  } vec_t;

  grant_t sb_q[$];
  vec_t   vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_check(input string name, input int k, input int lim);
    n_checks++;
    if (k >= lim) begin
      n_errors++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, k, lim);
    end
  endtask

  function automatic logic [31:0] lba_of(input logic [1:0] i);
    return 32'h100 * ({30'd0, i} + 32'd1);
  endfunction

  function automatic logic [5:0] blk_of(input logic [1:0] i);
    return 6'(3 + 7 * i);
  endfunction

  task automatic expect_grant(input logic [1:0] o, input logic r, input logic w);
    sb_q.push_back('{o, lba_of(o), blk_of(o), r, w});
  endtask

  // Scoreboard: each new host request must match the next expected grant.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    logic   req_now;
    grant_t g;
    req_now = sd_if.host_rd | sd_if.host_wr;
    if (req_now && !req_prev) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_grant: owner %0d with empty queue", owner);
      end else begin
        g = sb_q.pop_front();
        check("grant_owner", 32'(owner), 32'(g.owner));
        check("grant_lba", sd_if.host_lba, g.lba);
        check("grant_blk_cnt", 32'(sd_if.host_blk_cnt), 32'(g.blk));
        check("grant_rd", 32'(sd_if.host_rd), 32'(g.rd));
        check("grant_wr", 32'(sd_if.host_wr), 32'(g.wr));
      end
    end
    if (sd_if.drv_ack != 4'b0000)
      check("drv_ack_owner", 32'(sd_if.drv_ack), 32'd1 << owner);
    req_prev = req_now;
  end

  task automatic wait_req(output int lat);
    lat = 0;
    while (!(sd_if.host_rd || sd_if.host_wr) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bound_check("req_wait", lat, 40);
  endtask

  task automatic wait_idle(inout int ack_cyc);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      if (sd_if.drv_ack != 4'b0000) ack_cyc++;
      k++;
    end
    bound_check("idle_wait", k, 40);
  endtask

  task automatic serve(input int ack_len, output int ack_cyc, output int lat);
    wait_req(lat);
    sd_if.host_ack = 1'b1;
    ack_cyc = 0;
    for (int i = 0; i < ack_len; i++) begin
      @(negedge clk);
      if (i == 0) check("req_drop_on_ack", 32'({sd_if.host_rd, sd_if.host_wr}), 32'd0);
      if (sd_if.drv_ack != 4'b0000) ack_cyc++;
    end
    sd_if.host_ack = 1'b0;
    wait_idle(ack_cyc);
  endtask

  task automatic txn(input logic [3:0] rd, input logic [3:0] wr, input logic [1:0] o,
                     input logic hrd, input logic hwr, input int ack_len);
    int cyc, lat;
    expect_grant(o, hrd, hwr);
    sd_if.drv_rd = rd;
    sd_if.drv_wr = wr;
    serve(ack_len, cyc, lat);
    check("req_latency", 32'(lat), 32'd1);
    check("ack_cycles", 32'(cyc), 32'(ack_len + 1));
    sd_if.drv_rd = '0;
    sd_if.drv_wr = '0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_host_rd"}, 32'(sd_if.host_rd), 32'd0);
    check({tag, "_host_wr"}, 32'(sd_if.host_wr), 32'd0);
    check({tag, "_drv_ack"}, 32'(sd_if.drv_ack), 32'd0);
    check({tag, "_host_lba"}, sd_if.host_lba, 32'd0);
    check({tag, "_host_blk"}, 32'(sd_if.host_blk_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lat, k, hi, ack_seen;

    //            rd       wr       own  hrd  hwr  ack_len
    vecs[0] = '{4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 10};
    vecs[1] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1};
    vecs[2] = '{4'b0000, 4'b0001, 2'd0, 1'b0, 1'b1, 3};
    vecs[3] = '{4'b1001, 4'b0000, 2'd3, 1'b1, 1'b0, 2};
    vecs[4] = '{4'b0000, 4'b0110, 2'd1, 1'b0, 1'b1, 4};
    vecs[5] = '{4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0, 1};
    vecs[6] = '{4'b0100, 4'b0001, 2'd2, 1'b1, 1'b0, 2};
    vecs[7] = '{4'b0001, 4'b0010, 2'd0, 1'b1, 1'b0, 5};

    reset = 1'b1;
    sd_if.host_ack     = 1'b0;
    sd_if.host_buff_wr = 1'b0;
    sd_if.drv_rd       = '0;
    sd_if.drv_wr       = '0;
    for (int i = 0; i < 4; i++) begin
      sd_if.drv_lba[i]      = lba_of(2'(i));
      sd_if.drv_blk_cnt[i]  = blk_of(2'(i));
      sd_if.drv_buff_din[i] = 8'hA0 + 8'(i);
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // host_ack and buffer strobe while idle are ignored
    sd_if.host_ack     = 1'b1;
    sd_if.host_buff_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_busy", 32'(busy), 32'd0);
      check("idle_ack_drv_ack", 32'(sd_if.drv_ack), 32'd0);
      check("idle_buff_wr", 32'(sd_if.drv_buff_wr), 32'd0);
    end
    sd_if.host_ack     = 1'b0;
    sd_if.host_buff_wr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      txn(vecs[i].rd, vecs[i].wr, vecs[i].owner, vecs[i].hrd, vecs[i].hwr, vecs[i].ack_len);

    // buffer routing to owner 2, latched lba stability
    expect_grant(2'd2, 1'b1, 1'b0);
    sd_if.drv_rd = 4'b0100;
    wait_req(lat);
    sd_if.host_ack = 1'b1;
    @(negedge clk);
    check("buf_drv_ack", 32'(sd_if.drv_ack), 32'b0100);
    check("buf_wr_quiet", 32'(sd_if.drv_buff_wr), 32'd0);
    sd_if.host_buff_wr = 1'b1;
    #1;
    check("buf_wr_route", 32'(sd_if.drv_buff_wr), 32'b0100);
    check("buf_din_route", 32'(sd_if.host_buff_din), 32'hA2);
    sd_if.drv_buff_din[2] = 8'h5C;
    sd_if.drv_lba[2]      = 32'hDEAD_0000;
    #1;
    check("buf_din_follow", 32'(sd_if.host_buff_din), 32'h5C);
    @(negedge clk);
    check("lba_stable", sd_if.host_lba, 32'h300);
    sd_if.host_buff_wr = 1'b0;
    #1;
    check("buf_wr_drop", 32'(sd_if.drv_buff_wr), 32'd0);
    sd_if.drv_buff_din[2] = 8'hA2;
    sd_if.drv_lba[2]      = lba_of(2'd2);
    sd_if.host_ack        = 1'b0;
    sd_if.drv_rd          = '0;
    cyc = 0;
    wait_idle(cyc);
    @(negedge clk);

    // asynchronous reset in XFER
    expect_grant(2'd1, 1'b1, 1'b0);
    sd_if.drv_rd = 4'b0010;
    wait_req(lat);
    sd_if.host_ack = 1'b1;
    @(negedge clk);
    check("rst_pre_drv_ack", 32'(sd_if.drv_ack), 32'b0010);
    #1;
    reset          = 1'b1;
    sd_if.host_ack = 1'b0;
    sd_if.drv_rd   = '0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn(4'b1010, 4'b0000, 2'd1, 1'b1, 1'b0, 2);
    txn(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1);

    // contention: all four held, fair order 0,1,2,3,0
    expect_grant(2'd0, 1'b1, 1'b0);
    expect_grant(2'd1, 1'b1, 1'b0);
    expect_grant(2'd2, 1'b1, 1'b0);
    expect_grant(2'd3, 1'b1, 1'b0);
    expect_grant(2'd0, 1'b1, 1'b0);
    sd_if.drv_rd = 4'b1111;
    repeat (5) begin
      serve(2, cyc, lat);
      check("cont_ack_cycles", 32'(cyc), 32'd3);
    end
    sd_if.drv_rd = '0;
    @(negedge clk);

    // timeout with drive 1 waiting behind drive 0
    txn(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 1);
    expect_grant(2'd0, 1'b1, 1'b0);
    expect_grant(2'd1, 1'b1, 1'b0);
    expect_grant(2'd0, 1'b1, 1'b0);
    sd_if.drv_rd = 4'b0011;
    wait_req(lat);
    hi = 0;
    ack_seen = 0;
    while ((sd_if.host_rd || sd_if.host_wr) && hi < 30) begin
      if (sd_if.drv_ack != 4'b0000) ack_seen++;
      @(negedge clk);
      hi++;
    end
    check("to_rd_cycles", 32'(hi), 32'd8);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_no_ack", 32'(ack_seen + int'(sd_if.drv_ack != 4'b0000)), 32'd0);
    @(negedge clk);
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_next_owner", 32'(owner), 32'd1);
    serve(3, cyc, lat);
    check("to_d1_ack_cycles", 32'(cyc), 32'd4);
    sd_if.drv_rd = 4'b0001;
    serve(2, cyc, lat);
    check("to_d0_ack_cycles", 32'(cyc), 32'd3);
    sd_if.drv_rd = '0;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) k++;
    end
    check("final_idle", 32'(k), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
